// File: rtl/ysyx_25040109_mem_arbiter_pkg.sv
// Shared types for the core-side memory arbiter.
// FSM states, bus response codes and default widths.
package ysyx_25040109_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    I_AR,
    I_R,
    D_AR,
    D_R,
    D_WR,
    D_B
  } state_t;

  function automatic logic resp_err(
    input logic [1:0] resp
  );
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_25040109_mem_arbiter_if.sv
// Bundle of imem/dmem core channels and the downstream bus.
// master: arbiter view; slave: core plus memory view.
interface ysyx_25040109_mem_arbiter_if
  import ysyx_25040109_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  localparam int STRB_W = DATA_W / 8;

  logic              imem_arvalid;
  logic              imem_arready;
  logic [ADDR_W-1:0] imem_araddr;
  logic              imem_rvalid;
  logic              imem_rready;
  logic [DATA_W-1:0] imem_rdata;

  logic              dmem_arvalid;
  logic              dmem_arready;
  logic [ADDR_W-1:0] dmem_araddr;
  logic              dmem_rvalid;
  logic              dmem_rready;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_awvalid;
  logic              dmem_awready;
  logic [ADDR_W-1:0] dmem_awaddr;
  logic              dmem_wen;
  logic              dmem_wvalid;
  logic              dmem_wready;
  logic [DATA_W-1:0] dmem_wdata;
  logic [STRB_W-1:0] dmem_wmask;

  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_rvalid;
  logic              m_rready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_awvalid;
  logic              m_awready;
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_wvalid;
  logic              m_wready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_bvalid;
  logic              m_bready;
  logic [1:0]        m_bresp;

  logic              bus_err;

  modport master (
    input  imem_arvalid, imem_araddr,
    input  imem_rready,
    output imem_arready, imem_rvalid,
    output imem_rdata,
    input  dmem_arvalid, dmem_araddr,
    input  dmem_rready,
    output dmem_arready, dmem_rvalid,
    output dmem_rdata,
    input  dmem_awvalid, dmem_awaddr,
    input  dmem_wen, dmem_wvalid,
    input  dmem_wdata, dmem_wmask,
    output dmem_awready, dmem_wready,
    output m_arvalid, m_araddr,
    input  m_arready,
    input  m_rvalid, m_rdata, m_rresp,
    output m_rready,
    output m_awvalid, m_awaddr,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready,
    output bus_err
  );

  modport slave (
    output imem_arvalid, imem_araddr,
    output imem_rready,
    input  imem_arready, imem_rvalid,
    input  imem_rdata,
    output dmem_arvalid, dmem_araddr,
    output dmem_rready,
    input  dmem_arready, dmem_rvalid,
    input  dmem_rdata,
    output dmem_awvalid, dmem_awaddr,
    output dmem_wen, dmem_wvalid,
    output dmem_wdata, dmem_wmask,
    input  dmem_awready, dmem_wready,
    input  m_arvalid, m_araddr,
    output m_arready,
    output m_rvalid, m_rdata, m_rresp,
    input  m_rready,
    input  m_awvalid, m_awaddr,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready,
    input  bus_err
  );

endinterface

// File: rtl/ysyx_25040109_mem_arbiter.sv
// Two-master one-slave arbiter, one transaction in flight.
// Priority: dmem write, dmem read, imem read.
module ysyx_25040109_mem_arbiter
  import ysyx_25040109_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ysyx_25040109_mem_arbiter_if.master bus
);

  state_t state;
  state_t state_n;
  logic   aw_done;
  logic   aw_done_n;
  logic   w_done;
  logic   w_done_n;
  logic   aw_fire;
  logic   w_fire;

  // State and write-progress flags, sync active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Next state, flag updates and granted-channel routing.
  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;

    bus.imem_arready = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;
    bus.dmem_arready = 1'b0;
    bus.dmem_rvalid  = 1'b0;
    bus.dmem_rdata   = '0;
    bus.dmem_awready = 1'b0;
    bus.dmem_wready  = 1'b0;

    bus.m_arvalid = 1'b0;
    bus.m_araddr  = '0;
    bus.m_rready  = 1'b0;
    bus.m_awvalid = 1'b0;
    bus.m_awaddr  = bus.dmem_awaddr;
    bus.m_wvalid  = 1'b0;
    bus.m_wdata   = bus.dmem_wdata;
    bus.m_wstrb   = bus.dmem_wmask;
    bus.m_bready  = 1'b0;
    bus.bus_err   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.dmem_awvalid && bus.dmem_wen) begin
          state_n = D_WR;
        end else if (bus.dmem_arvalid) begin
          state_n = D_AR;
        end else if (bus.imem_arvalid) begin
          state_n = I_AR;
        end
      end

      I_AR: begin
        bus.m_arvalid    = bus.imem_arvalid;
        bus.m_araddr     = bus.imem_araddr;
        bus.imem_arready = bus.m_arready;
        if (bus.imem_arvalid && bus.m_arready) begin
          state_n = I_R;
        end
      end

      I_R: begin
        bus.imem_rvalid = bus.m_rvalid;
        bus.imem_rdata  = bus.m_rdata;
        bus.m_rready    = bus.imem_rready;
        if (bus.m_rvalid && bus.imem_rready) begin
          bus.bus_err = resp_err(bus.m_rresp);
          state_n     = IDLE;
        end
      end

      D_AR: begin
        bus.m_arvalid    = bus.dmem_arvalid;
        bus.m_araddr     = bus.dmem_araddr;
        bus.dmem_arready = bus.m_arready;
        if (bus.dmem_arvalid && bus.m_arready) begin
          state_n = D_R;
        end
      end

      D_R: begin
        bus.dmem_rvalid = bus.m_rvalid;
        bus.dmem_rdata  = bus.m_rdata;
        bus.m_rready    = bus.dmem_rready;
        if (bus.m_rvalid && bus.dmem_rready) begin
          bus.bus_err = resp_err(bus.m_rresp);
          state_n     = IDLE;
        end
      end

      D_WR: begin
        bus.m_awvalid    = bus.dmem_awvalid && !aw_done;
        bus.m_wvalid     = bus.dmem_wvalid && !w_done;
        bus.dmem_awready = bus.m_awready && !aw_done;
        aw_fire = bus.dmem_awvalid && !aw_done
                && bus.m_awready;
        w_fire  = bus.dmem_wvalid && !w_done
                && bus.m_wready;
        aw_done_n = aw_done || aw_fire;
        w_done_n  = w_done || w_fire;
        if (aw_done_n && w_done_n) begin
          state_n = D_B;
        end
      end

      D_B: begin
        bus.m_bready = 1'b1;
        if (bus.m_bvalid) begin
          bus.dmem_wready = 1'b1;
          bus.bus_err     = resp_err(bus.m_bresp);
          aw_done_n       = 1'b0;
          w_done_n        = 1'b0;
          state_n         = IDLE;
        end
      end

      default: begin
        state_n   = IDLE;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040109_mem_arbiter.sv
// Directed bench for the core memory arbiter.
// Drives core and memory sides cycle by cycle.
module tb_ysyx_25040109_mem_arbiter;
  import ysyx_25040109_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ysyx_25040109_mem_arbiter_if bus ();

  ysyx_25040109_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {imem_arready, imem_rvalid, dmem_arready,
  //  dmem_rvalid, dmem_awready, dmem_wready,
  //  m_arvalid, m_rready, m_awvalid, m_wvalid,
  //  m_bready, bus_err}
  function automatic logic [11:0] vr();
    return {bus.imem_arready, bus.imem_rvalid,
            bus.dmem_arready, bus.dmem_rvalid,
            bus.dmem_awready, bus.dmem_wready,
            bus.m_arvalid, bus.m_rready,
            bus.m_awvalid, bus.m_wvalid,
            bus.m_bready, bus.bus_err};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #4;
  endtask

  task automatic clr();
    bus.imem_arvalid = 0; bus.imem_araddr = '0;
    bus.imem_rready  = 0;
    bus.dmem_arvalid = 0; bus.dmem_araddr = '0;
    bus.dmem_rready  = 0;
    bus.dmem_awvalid = 0; bus.dmem_awaddr = '0;
    bus.dmem_wen     = 0; bus.dmem_wvalid = 0;
    bus.dmem_wdata   = '0; bus.dmem_wmask = '0;
    bus.m_arready = 0;
    bus.m_rvalid  = 0; bus.m_rdata = '0;
    bus.m_rresp   = RESP_OKAY;
    bus.m_awready = 0; bus.m_wready = 0;
    bus.m_bvalid  = 0; bus.m_bresp = RESP_OKAY;
  endtask

  task automatic test_reset();
    rst = 0;
    clr();
    bus.imem_arvalid = 1;
    bus.dmem_arvalid = 1;
    bus.m_rvalid = 1;
    bus.m_bvalid = 1;
    nxt(); nxt(); smp();
    checks++;
    if (vr() !== 12'h000) begin
      failures++;
      $display("FAIL rst_hold vr got=%h exp=%h",
               vr(), 12'h000);
    end
    nxt();
    rst = 1;
    clr();
    smp();
    checks++;
    if (vr() !== 12'h000) begin
      failures++;
      $display("FAIL rst_after vr got=%h exp=%h",
               vr(), 12'h000);
    end
  endtask

  task automatic test_imem_read();
    logic [11:0] exp_vr [6];
    exp_vr = '{12'h000, 12'h820, 12'h010,
               12'h010, 12'h410, 12'h000};
    for (int c = 0; c < 6; c++) begin
      nxt();
      if (c == 0) begin
        bus.imem_arvalid = 1;
        bus.imem_araddr  = 32'h8000_0000;
        bus.imem_rready  = 1;
        bus.m_arready    = 1;
      end
      if (c == 2) bus.imem_arvalid = 0;
      if (c == 4) begin
        bus.m_rvalid = 1;
        bus.m_rdata  = 32'h0000_0413;
      end
      if (c == 5) clr();
      smp();
      checks++;
      if (vr() !== exp_vr[c]) begin
        failures++;
        $display("FAIL imem_c%0d vr got=%h exp=%h",
                 c, vr(), exp_vr[c]);
      end
      if (c == 1) begin
        checks++;
        if (bus.m_araddr !== 32'h8000_0000) begin
          failures++;
          $display("FAIL imem_araddr got=%h exp=%h",
                   bus.m_araddr, 32'h8000_0000);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.imem_rdata !== 32'h0000_0413) begin
          failures++;
          $display("FAIL imem_rdata got=%h exp=%h",
                   bus.imem_rdata, 32'h0000_0413);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [11:0] exp_vr [7];
    exp_vr = '{12'h000, 12'h220, 12'h110, 12'h000,
               12'h820, 12'h410, 12'h000};
    for (int c = 0; c < 7; c++) begin
      nxt();
      if (c == 0) begin
        bus.imem_arvalid = 1;
        bus.imem_araddr  = 32'h8000_0100;
        bus.imem_rready  = 1;
        bus.dmem_arvalid = 1;
        bus.dmem_araddr  = 32'h8000_2000;
        bus.dmem_rready  = 1;
        bus.m_arready    = 1;
      end
      if (c == 2) begin
        bus.dmem_arvalid = 0;
        bus.m_rvalid = 1;
        bus.m_rdata  = 32'h1111_2222;
      end
      if (c == 3) bus.m_rvalid = 0;
      if (c == 5) begin
        bus.imem_arvalid = 0;
        bus.m_rvalid = 1;
        bus.m_rdata  = 32'h3333_4444;
      end
      if (c == 6) clr();
      smp();
      checks++;
      if (vr() !== exp_vr[c]) begin
        failures++;
        $display("FAIL prio_c%0d vr got=%h exp=%h",
                 c, vr(), exp_vr[c]);
      end
      if (c == 1) begin
        checks++;
        if (bus.m_araddr !== 32'h8000_2000) begin
          failures++;
          $display("FAIL prio_d_addr got=%h exp=%h",
                   bus.m_araddr, 32'h8000_2000);
        end
      end
      if (c == 2) begin
        checks++;
        if (bus.dmem_rdata !== 32'h1111_2222) begin
          failures++;
          $display("FAIL prio_d_rdata got=%h exp=%h",
                   bus.dmem_rdata, 32'h1111_2222);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.m_araddr !== 32'h8000_0100) begin
          failures++;
          $display("FAIL prio_i_addr got=%h exp=%h",
                   bus.m_araddr, 32'h8000_0100);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.imem_rdata !== 32'h3333_4444) begin
          failures++;
          $display("FAIL prio_i_rdata got=%h exp=%h",
                   bus.imem_rdata, 32'h3333_4444);
        end
      end
    end
  endtask

  task automatic test_store();
    logic [11:0] exp_vr [7];
    exp_vr = '{12'h000, 12'h00C, 12'h008, 12'h088,
               12'h002, 12'h042, 12'h000};
    for (int c = 0; c < 7; c++) begin
      nxt();
      if (c == 0) begin
        bus.dmem_awvalid = 1;
        bus.dmem_awaddr  = 32'h8000_1000;
        bus.dmem_wen     = 1;
        bus.dmem_wvalid  = 1;
        bus.dmem_wdata   = 32'hDEAD_BEEF;
        bus.dmem_wmask   = 4'b0011;
        bus.m_wready     = 1;
      end
      if (c == 3) bus.m_awready = 1;
      if (c == 4) bus.m_awready = 0;
      if (c == 5) bus.m_bvalid = 1;
      if (c == 6) clr();
      smp();
      checks++;
      if (vr() !== exp_vr[c]) begin
        failures++;
        $display("FAIL store_c%0d vr got=%h exp=%h",
                 c, vr(), exp_vr[c]);
      end
      if (c == 1) begin
        checks++;
        if ({bus.m_wdata, bus.m_wstrb} !==
            {32'hDEAD_BEEF, 4'b0011}) begin
          failures++;
          $display("FAIL store_w got=%h/%b exp=%h/%b",
                   bus.m_wdata, bus.m_wstrb,
                   32'hDEAD_BEEF, 4'b0011);
        end
      end
      if (c == 3) begin
        checks++;
        if (bus.m_awaddr !== 32'h8000_1000) begin
          failures++;
          $display("FAIL store_awaddr got=%h exp=%h",
                   bus.m_awaddr, 32'h8000_1000);
        end
      end
    end
  endtask

  task automatic test_load_err();
    logic [11:0] exp_vr [4];
    exp_vr = '{12'h000, 12'h220, 12'h111, 12'h000};
    for (int c = 0; c < 4; c++) begin
      nxt();
      if (c == 0) begin
        bus.dmem_awvalid = 1;
        bus.dmem_wen     = 0;
        bus.dmem_wvalid  = 1;
        bus.dmem_arvalid = 1;
        bus.dmem_araddr  = 32'h8000_3000;
        bus.dmem_rready  = 1;
        bus.m_arready    = 1;
      end
      if (c == 2) begin
        bus.dmem_arvalid = 0;
        bus.dmem_awvalid = 0;
        bus.dmem_wvalid  = 0;
        bus.m_rvalid = 1;
        bus.m_rdata  = 32'hCAFE_F00D;
        bus.m_rresp  = RESP_SLVERR;
      end
      if (c == 3) clr();
      smp();
      checks++;
      if (vr() !== exp_vr[c]) begin
        failures++;
        $display("FAIL lerr_c%0d vr got=%h exp=%h",
                 c, vr(), exp_vr[c]);
      end
      if (c == 2) begin
        checks++;
        if (bus.dmem_rdata !== 32'hCAFE_F00D) begin
          failures++;
          $display("FAIL lerr_rdata got=%h exp=%h",
                   bus.dmem_rdata, 32'hCAFE_F00D);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp_vr [7];
    exp_vr = '{12'h000, 12'h08C, 12'h002, 12'h000,
               12'h820, 12'h410, 12'h000};
    for (int c = 0; c < 7; c++) begin
      nxt();
      if (c == 0) begin
        bus.dmem_awvalid = 1;
        bus.dmem_awaddr  = 32'h8000_5000;
        bus.dmem_wen     = 1;
        bus.dmem_wvalid  = 1;
        bus.dmem_wdata   = 32'h5555_AAAA;
        bus.dmem_wmask   = 4'hF;
        bus.m_awready    = 1;
        bus.m_wready     = 1;
      end
      if (c == 2) begin
        clr();
        rst = 0;
      end
      if (c == 3) begin
        rst = 1;
        bus.imem_arvalid = 1;
        bus.imem_araddr  = 32'h8000_0004;
        bus.imem_rready  = 1;
        bus.m_arready    = 1;
      end
      if (c == 5) begin
        bus.imem_arvalid = 0;
        bus.m_rvalid = 1;
        bus.m_rdata  = 32'h0010_0093;
      end
      if (c == 6) clr();
      smp();
      checks++;
      if (vr() !== exp_vr[c]) begin
        failures++;
        $display("FAIL rmid_c%0d vr got=%h exp=%h",
                 c, vr(), exp_vr[c]);
      end
      if (c == 5) begin
        checks++;
        if (bus.imem_rdata !== 32'h0010_0093) begin
          failures++;
          $display("FAIL rmid_rdata got=%h exp=%h",
                   bus.imem_rdata, 32'h0010_0093);
        end
      end
    end
  endtask

  task automatic test_store_berr();
    logic [11:0] exp_vr [4];
    exp_vr = '{12'h000, 12'h08C, 12'h043, 12'h000};
    for (int c = 0; c < 4; c++) begin
      nxt();
      if (c == 0) begin
        bus.dmem_awvalid = 1;
        bus.dmem_awaddr  = 32'h8000_4000;
        bus.dmem_wen     = 1;
        bus.dmem_wvalid  = 1;
        bus.dmem_wdata   = 32'h1234_5678;
        bus.dmem_wmask   = 4'hF;
        bus.dmem_arvalid = 1;
        bus.m_awready    = 1;
        bus.m_wready     = 1;
      end
      if (c == 2) begin
        bus.m_awready = 0;
        bus.m_wready  = 0;
        bus.m_bvalid  = 1;
        bus.m_bresp   = RESP_DECERR;
      end
      if (c == 3) clr();
      smp();
      checks++;
      if (vr() !== exp_vr[c]) begin
        failures++;
        $display("FAIL berr_c%0d vr got=%h exp=%h",
                 c, vr(), exp_vr[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_imem_read();
    test_priority();
    test_store();
    test_load_err();
    test_reset_mid();
    test_store_berr();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_25040109_mem_arbiter.md
# ysyx_25040109_mem_arbiter

Two-master, one-slave bus arbiter directly downstream of the CPU core's instruction-fetch and data-access channels. It merges the read-only instruction channel and the read/write data channel onto a single AXI4-Lite-style master port toward memory/peripherals. Exactly one transaction is outstanding at a time. Fixed priority: dmem write, then dmem read, then imem read.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- imem_arvalid / imem_arready  in / out  1  instruction read-address handshake
- imem_araddr  in  ADDR_W  instruction address
- imem_rvalid / imem_rready  out / in  1  instruction read-data handshake
- imem_rdata  out  DATA_W  instruction word
- dmem_arvalid / dmem_arready  in / out  1  data read-address handshake
- dmem_araddr  in  ADDR_W  load address
- dmem_rvalid / dmem_rready  out / in  1  load-data handshake
- dmem_rdata  out  DATA_W  load data
- dmem_awvalid / dmem_awready  in / out  1  store-address handshake
- dmem_awaddr  in  ADDR_W  store address
- dmem_wen  in  1  store qualifier
- dmem_wvalid / dmem_wready  in / out  1  store-data handshake; wready means write complete
- dmem_wdata  in  DATA_W  store data
- dmem_wmask  in  DATA_W/8  byte mask
- m_arvalid, m_arready, m_araddr  out/in/out  1/1/ADDR_W  downstream AR
- m_rvalid, m_rready, m_rdata, m_rresp  in/out/in/in  1/1/DATA_W/2  downstream R
- m_awvalid, m_awready, m_awaddr  out/in/out  1/1/ADDR_W  downstream AW
- m_wvalid, m_wready, m_wdata, m_wstrb  out/in/out/out  1/1/DATA_W/(DATA_W/8)  downstream W
- m_bvalid, m_bready, m_bresp  in/out/in  1/1/2  downstream B
- bus_err  out  1  one-cycle pulse on a non-OKAY rresp or bresp

## Operation
- States: IDLE, I_AR, I_R, D_AR, D_R, D_WR, D_B.
- IDLE transitions, evaluated in priority order:
  - (dmem_awvalid && dmem_wen) -> D_WR
  - else dmem_arvalid -> D_AR
  - else imem_arvalid -> I_AR
  - else stay.
- IDLE behaviour: all master-side readies/valids and all m_* valids/readies are 0. The grant decision is registered.
- I_AR / D_AR:
  - m_araddr = granted araddr; m_arvalid = granted arvalid.
  - Granted arready = m_arready; non-granted arready = 0.
  - On AR fire -> I_R / D_R.
- I_R / D_R:
  - Granted rvalid = m_rvalid, rdata = m_rdata.
  - m_rready = granted rready.
  - On R fire -> IDLE.
- D_WR:
  - m_awvalid = dmem_awvalid && !aw_done; m_wvalid = dmem_wvalid && !w_done.
  - dmem_awready = m_awready && !aw_done.
  - aw_done and w_done flags set on their respective fires; AW and W complete in either order or the same cycle.
  - When both flags are set (including flags set this cycle) -> D_B.
- D_B:
  - m_bready = 1.
  - On m_bvalid: dmem_wready = 1 for that cycle, clear both flags, -> IDLE.
  - dmem_wready is 0 in all other states.
- bus_err pulses in the cycle of an R or B fire whose resp != 2'b00. Data is still delivered.
- The non-granted master stays stalled with ready=0 and may hold valid indefinitely.
- Addresses and data pass through unmodified. Width is unchanged, with no realignment.

## Timing
- Reset (rst=0 at posedge): state=IDLE, aw_done=w_done=0, bus_err=0. All valid/ready outputs are 0 in the cycle after reset. Reset mid-transaction abandons it; the downstream slave is reset concurrently.
- Grant latency: request seen in IDLE at cycle N; m_*valid asserted at N+1.
- No added latency after grant: ready/valid are combinational passthrough.
- Minimum read: 3 cycles (IDLE, AR, R) when the slave responds in zero cycles. Minimum write: 3 cycles (IDLE, D_WR, D_B).
- Back-to-back: returning to IDLE costs one bubble cycle before the next grant.
- Simultaneous requests in IDLE: dmem write wins over dmem read over imem. A losing request is held and granted on the next IDLE.
- A request that arrives while not in IDLE is ignored until IDLE.

## Structure
- Shared package holds:
  - state enum
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
- Single flat module; no sub-module. FSM plus two done-flags.

## Test plan
- imem read of 0x80000000; slave returns 0x00000413 with 2-cycle rvalid delay -> imem_rdata=0x00000413, imem_rvalid for 1 cycle, dmem_* quiet.
- imem_arvalid and dmem_arvalid asserted in the same IDLE cycle -> dmem granted first (m_araddr=dmem_araddr), imem granted after the dmem R fire plus one IDLE cycle.
- Store 0xDEADBEEF to 0x80001000 with mask 4'b0011; slave accepts W two cycles before AW -> one m_awvalid fire, one m_wvalid fire, m_wstrb=4'b0011, dmem_wready for 1 cycle after bvalid.
- Load with m_rresp=2'b10 -> dmem_rdata delivered and bus_err=1 for exactly that cycle.
- rst=0 asserted while in D_B waiting on bvalid -> next cycle state IDLE, all valid/ready outputs 0, a subsequent imem read completes normally.
